// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage : instruction-decode stage of a five-stage MIPS-style pipeline.
//
// Contains the IF/ID pipeline latch, a 32x32 register file with write-through
// bypass, the load-use hazard detector and the combinational main decoder.
//
// Ports
//   CLK, RESET            rising-edge clock, synchronous active-low reset
//   instruction_in        instruction word from fetch
//   PCPlus4_in            PC+4 from fetch
//   flush                 taken jump/branch resolved in memory stage
//   RegWrite_WB, WriteReg_WB, WriteData_WB   writeback port into the regfile
//   EX_MemRead, EX_Rt     load currently in execute (for load-use detection)
//   stall                 high holds the fetch PC and this latch
//   valid_out             latch holds a real instruction
//   PCPlus4_out           latched PC+4
//   ReadData1/2           register operands rs / rt
//   Imm                   extended immediate
//   Rs, Rt, Rd, shamt     instruction fields (Rd forced to 31 for jal)
//   RegWrite..Jump        control bits, ALUControl 4-bit ALU operation
//   halt                  sticky flag raised by the 0xFFFFFFFF terminate word
//
// Handshake: this stage has no valid/ready pair; valid_out qualifies every
// output and stall is the backpressure toward fetch. A cycle with stall=1 or
// valid_out=0 carries a bubble (all control bits 0).
// ----------------------------------------------------------------------------
module id_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction_in,
  input  logic [31:0] PCPlus4_in,
  input  logic        flush,
  input  logic        RegWrite_WB,
  input  logic [4:0]  WriteReg_WB,
  input  logic [31:0] WriteData_WB,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] PCPlus4_out,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] Imm,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  shamt,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        Branch,
  output logic        BranchNE,
  output logic        Jump,
  output logic [3:0]  ALUControl,
  output logic        halt
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // IF/ID latch
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;

  logic [31:0] regs [32];

  // Priority: reset > flush > stall > load. On flush pc4 is left as-is; it
  // is meaningless once valid drops.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      instr <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= 32'h0;
      valid <= 1'b0;
    end else if (!stall) begin
      instr <= instruction_in;
      pc4   <= PCPlus4_in;
      valid <= 1'b1;
    end
  end

  // Register file; $0 is never written.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (RegWrite_WB && (WriteReg_WB != 5'd0)) begin
      regs[WriteReg_WB] <= WriteData_WB;
    end
  end

  // Sticky halt flag.
  always_ff @(posedge CLK) begin
    if (!RESET)
      halt <= 1'b0;
    else if (valid && (instr == HALT_WORD))
      halt <= 1'b1;
  end

  // Field extraction
  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  assign Rs          = instr[25:21];
  assign Rt          = instr[20:16];
  assign Rd          = (opcode == OP_JAL) ? 5'd31 : instr[15:11];
  assign shamt       = instr[10:6];
  assign valid_out   = valid;
  assign PCPlus4_out = pc4;

  // Logical immediates zero-extend, everything else sign-extends.
  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      Imm = {16'h0, instr[15:0]};
    else
      Imm = {{16{instr[15]}}, instr[15:0]};
  end

  // Read ports with write-through bypass so a same-cycle writeback is seen.
  always_comb begin
    if (Rs == 5'd0)
      ReadData1 = 32'h0;
    else if (RegWrite_WB && (WriteReg_WB == Rs))
      ReadData1 = WriteData_WB;
    else
      ReadData1 = regs[Rs];

    if (Rt == 5'd0)
      ReadData2 = 32'h0;
    else if (RegWrite_WB && (WriteReg_WB == Rt))
      ReadData2 = WriteData_WB;
    else
      ReadData2 = regs[Rt];
  end

  // Load-use hazard: only R-type, sw, beq and bne consume rt as a source.
  logic reads_rt;
  assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_BNE);

  assign stall = valid && EX_MemRead && (EX_Rt != 5'd0) &&
                 ((EX_Rt == Rs) || ((EX_Rt == Rt) && reads_rt));

  // Raw decode, before bubble gating.
  logic       d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
  logic       d_alu_src, d_reg_dst, d_branch, d_branch_ne, d_jump;
  logic [3:0] d_alu;

  always_comb begin
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src    = 1'b0;
    d_reg_dst    = 1'b0;
    d_branch     = 1'b0;
    d_branch_ne  = 1'b0;
    d_jump       = 1'b0;
    d_alu        = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        d_reg_dst   = 1'b1;
        d_reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24:        d_alu = ALU_AND;
          6'h25:        d_alu = ALU_OR;
          6'h26:        d_alu = ALU_XOR;
          6'h27:        d_alu = ALU_NOR;
          6'h2A:        d_alu = ALU_SLT;
          6'h00, 6'h04: d_alu = ALU_SLL;
          6'h02, 6'h06: d_alu = ALU_SRL;
          6'h03, 6'h07: d_alu = ALU_SRA;
          6'h08: begin
            // jr: target comes from ReadData1, nothing is written back.
            d_reg_write = 1'b0;
            d_jump      = 1'b1;
          end
          default: begin
            d_reg_dst   = 1'b0;
            d_reg_write = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
        d_alu_src    = 1'b1;
      end
      OP_SW: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        d_branch = 1'b1;
        d_alu    = ALU_SUB;
      end
      OP_BNE: begin
        d_branch_ne = 1'b1;
        d_alu       = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_ANDI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_alu       = ALU_AND;
      end
      OP_ORI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_alu       = ALU_OR;
      end
      OP_XORI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_alu       = ALU_XOR;
      end
      OP_J: d_jump = 1'b1;
      OP_JAL: begin
        d_reg_write = 1'b1;
        d_jump      = 1'b1;
      end
      default: ;  // unknown opcode (including the halt word) -> bubble
    endcase
  end

  logic bubble;
  assign bubble = stall || !valid;

  assign RegWrite   = d_reg_write  & ~bubble;
  assign MemRead    = d_mem_read   & ~bubble;
  assign MemWrite   = d_mem_write  & ~bubble;
  assign MemtoReg   = d_mem_to_reg & ~bubble;
  assign ALUSrc     = d_alu_src    & ~bubble;
  assign RegDst     = d_reg_dst    & ~bubble;
  assign Branch     = d_branch     & ~bubble;
  assign BranchNE   = d_branch_ne  & ~bubble;
  assign Jump       = d_jump       & ~bubble;
  assign ALUControl = bubble ? 4'd0 : d_alu;

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage : directed bench for id_stage. A table of instruction words
// with hand-decoded expectations, followed by hand-written sequences for the
// bypass, load-use stall, flush, $0 write and halt behaviours.
// ----------------------------------------------------------------------------
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] instruction_in;
  logic [31:0] PCPlus4_in;
  logic        flush;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] WriteData_WB;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        stall, valid_out;
  logic [31:0] PCPlus4_out, ReadData1, ReadData2, Imm;
  logic [4:0]  Rs, Rt, Rd, shamt;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst;
  logic        Branch, BranchNE, Jump, halt;
  logic [3:0]  ALUControl;

  id_stage dut (
    .CLK(CLK), .RESET(RESET), .instruction_in(instruction_in),
    .PCPlus4_in(PCPlus4_in), .flush(flush), .RegWrite_WB(RegWrite_WB),
    .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .stall(stall),
    .valid_out(valid_out), .PCPlus4_out(PCPlus4_out),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .Branch(Branch), .BranchNE(BranchNE), .Jump(Jump),
    .ALUControl(ALUControl), .halt(halt)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required summary before timeout");
    $fatal(1, "watchdog");
  end

  // Control bits packed as {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,
  // RegDst,Branch,BranchNE,Jump}
  localparam logic [8:0] C_RW  = 9'b100000000;
  localparam logic [8:0] C_MR  = 9'b010000000;
  localparam logic [8:0] C_MW  = 9'b001000000;
  localparam logic [8:0] C_MTR = 9'b000100000;
  localparam logic [8:0] C_AS  = 9'b000010000;
  localparam logic [8:0] C_RD  = 9'b000001000;
  localparam logic [8:0] C_BR  = 9'b000000100;
  localparam logic [8:0] C_BNE = 9'b000000010;
  localparam logic [8:0] C_J   = 9'b000000001;

  logic [8:0] ctrl;
  assign ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc,
                 RegDst, Branch, BranchNE, Jump};

  typedef struct {
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after
  // that, well away from the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load(input logic [31:0] w, input logic [31:0] p);
    instruction_in = w;
    PCPlus4_in     = p;
    tick();
  endtask

  initial begin
    // Stimulus table: hand-decoded expectations
    vecs[0]  = '{32'h20080005, C_RW|C_AS,            4'd0, 32'h00000005, 5'd8,  5'd0,  5'd0};  // addi $8,$0,5
    vecs[1]  = '{32'h014C5820, C_RW|C_RD,            4'd0, 32'h00005820, 5'd12, 5'd11, 5'd0};  // add
    vecs[2]  = '{32'h00221822, C_RW|C_RD,            4'd1, 32'h00001822, 5'd2,  5'd3,  5'd0};  // sub
    vecs[3]  = '{32'h8CC5FFFC, C_RW|C_MR|C_MTR|C_AS, 4'd0, 32'hFFFFFFFC, 5'd5,  5'd31, 5'd31}; // lw
    vecs[4]  = '{32'hACC50008, C_MW|C_AS,            4'd0, 32'h00000008, 5'd5,  5'd0,  5'd0};  // sw
    vecs[5]  = '{32'h1022FFFF, C_BR,                 4'd1, 32'hFFFFFFFF, 5'd2,  5'd31, 5'd31}; // beq
    vecs[6]  = '{32'h14220003, C_BNE,                4'd1, 32'h00000003, 5'd2,  5'd0,  5'd0};  // bne
    vecs[7]  = '{32'h30848000, C_RW|C_AS,            4'd2, 32'h00008000, 5'd4,  5'd16, 5'd0};  // andi zero-ext
    vecs[8]  = '{32'h3484FFFF, C_RW|C_AS,            4'd3, 32'h0000FFFF, 5'd4,  5'd31, 5'd31}; // ori zero-ext
    vecs[9]  = '{32'h388400F0, C_RW|C_AS,            4'd4, 32'h000000F0, 5'd4,  5'd0,  5'd3};  // xori
    vecs[10] = '{32'h00031103, C_RW|C_RD,            4'd9, 32'h00001103, 5'd3,  5'd2,  5'd4};  // sra
    vecs[11] = '{32'h00831004, C_RW|C_RD,            4'd7, 32'h00001004, 5'd3,  5'd2,  5'd0};  // sllv
    vecs[12] = '{32'h00221827, C_RW|C_RD,            4'd5, 32'h00001827, 5'd2,  5'd3,  5'd0};  // nor
    vecs[13] = '{32'h0022182A, C_RW|C_RD,            4'd6, 32'h0000182A, 5'd2,  5'd3,  5'd0};  // slt
    vecs[14] = '{32'h03E00008, C_RD|C_J,             4'd0, 32'h00000008, 5'd0,  5'd0,  5'd0};  // jr $31
    vecs[15] = '{32'h08000100, C_J,                  4'd0, 32'h00000100, 5'd0,  5'd0,  5'd4};  // j
    vecs[16] = '{32'h0C000100, C_RW|C_J,             4'd0, 32'h00000100, 5'd0,  5'd31, 5'd4};  // jal
    vecs[17] = '{32'h00221801, 9'd0,                 4'd0, 32'h00001801, 5'd2,  5'd3,  5'd0};  // bad funct
    vecs[18] = '{32'hFC000000, 9'd0,                 4'd0, 32'h00000000, 5'd0,  5'd0,  5'd0};  // bad opcode
    vecs[19] = '{32'h00000000, C_RW|C_RD,            4'd7, 32'h00000000, 5'd0,  5'd0,  5'd0};  // nop
    vecs[20] = '{32'h00831006, C_RW|C_RD,            4'd8, 32'h00001006, 5'd3,  5'd2,  5'd0};  // srlv

    // Reset
    RESET = 1'b0; flush = 1'b0; RegWrite_WB = 1'b0; WriteReg_WB = 5'd0;
    WriteData_WB = 32'h0; EX_MemRead = 1'b0; EX_Rt = 5'd0;
    instruction_in = 32'h20080005; PCPlus4_in = 32'h4;
    tick(); tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ctrl", {23'd0, ctrl}, 32'd0);
    check("rst_alu", {28'd0, ALUControl}, 32'd0);
    check("rst_rd1", ReadData1, 32'd0);
    check("rst_rd2", ReadData2, 32'd0);
    check("rst_imm", Imm, 32'd0);
    check("rst_pc4", PCPlus4_out, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    RESET = 1'b1;
    settle();
    check("post_rst_valid", {31'd0, valid_out}, 32'd0);

    // Table-driven decode
    for (int i = 0; i < NVEC; i++) begin
      load(vecs[i].instr, 32'(4 * (i + 1)));
      check($sformatf("v%0d_valid", i), {31'd0, valid_out}, 32'd1);
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d_ctrl", i), {23'd0, ctrl}, {23'd0, vecs[i].ctrl});
      check($sformatf("v%0d_alu", i), {28'd0, ALUControl}, {28'd0, vecs[i].alu});
      check($sformatf("v%0d_imm", i), Imm, vecs[i].imm);
      check($sformatf("v%0d_rt", i), {27'd0, Rt}, {27'd0, vecs[i].rt});
      check($sformatf("v%0d_rd", i), {27'd0, Rd}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_shamt", i), {27'd0, shamt}, {27'd0, vecs[i].sh});
      check($sformatf("v%0d_pc4", i), PCPlus4_out, 32'(4 * (i + 1)));
    end

    // Write-through bypass: add $11,$9,$0 latched, $9 written same cycle
    load(32'h01205820, 32'h40);
    RegWrite_WB = 1'b1; WriteReg_WB = 5'd9; WriteData_WB = 32'hDEADBEEF;
    settle();
    check("bypass_rd1", ReadData1, 32'hDEADBEEF);
    check("bypass_rd2_zero", ReadData2, 32'h0);
    tick();
    RegWrite_WB = 1'b0; WriteData_WB = 32'h0;
    settle();
    check("stored_rd1", ReadData1, 32'hDEADBEEF);

    // Write to $0 is ignored: add $1,$0,$0 latched
    load(32'h00000820, 32'h44);
    RegWrite_WB = 1'b1; WriteReg_WB = 5'd0; WriteData_WB = 32'h1234;
    settle();
    check("r0_same_cycle", ReadData1, 32'h0);
    tick();
    RegWrite_WB = 1'b0;
    settle();
    check("r0_after_write", ReadData1, 32'h0);

    // Load-use stall on rs: add $11,$10,$12 vs load to $10
    load(32'h014C5820, 32'h100);
    EX_MemRead = 1'b1; EX_Rt = 5'd10;
    instruction_in = 32'h20080005; PCPlus4_in = 32'h200;
    settle();
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_ctrl_bubble", {23'd0, ctrl}, 32'd0);
    tick();
    check("lu_held_stall", {31'd0, stall}, 32'd1);
    check("lu_held_imm", Imm, 32'h00005820);
    check("lu_held_pc4", PCPlus4_out, 32'h100);
    check("lu_held_valid", {31'd0, valid_out}, 32'd1);
    EX_Rt = 5'd12;
    settle();
    check("lu_rt_stall", {31'd0, stall}, 32'd1);
    EX_Rt = 5'd0;
    settle();
    check("lu_r0_nostall", {31'd0, stall}, 32'd0);
    EX_MemRead = 1'b0; EX_Rt = 5'd10;
    settle();
    check("lu_release_stall", {31'd0, stall}, 32'd0);
    check("lu_release_ctrl", {23'd0, ctrl}, {23'd0, C_RW | C_RD});
    tick();
    // addi $8 does not read rt, so a load to $8 must not stall it
    EX_MemRead = 1'b1; EX_Rt = 5'd8;
    settle();
    check("lu_addi_rt_nostall", {31'd0, stall}, 32'd0);
    EX_MemRead = 1'b0;

    // Flush and stall together: flush wins
    load(32'h014C5820, 32'h300);
    EX_MemRead = 1'b1; EX_Rt = 5'd10; flush = 1'b1;
    settle();
    check("fl_pre_stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    settle();
    check("fl_valid", {31'd0, valid_out}, 32'd0);
    check("fl_imm_zero", Imm, 32'h0);
    check("fl_rs_zero", {27'd0, Rs}, 32'd0);
    check("fl_stall", {31'd0, stall}, 32'd0);
    check("fl_ctrl", {23'd0, ctrl}, 32'd0);
    EX_MemRead = 1'b0; EX_Rt = 5'd0;

    // Halt: sets the edge after it is latched, sticky until reset
    load(32'hFFFFFFFF, 32'h400);
    check("halt_latched_bubble", {23'd0, ctrl}, 32'd0);
    check("halt_not_yet", {31'd0, halt}, 32'd0);
    load(32'h00000000, 32'h404);
    check("halt_set", {31'd0, halt}, 32'd1);
    for (int k = 0; k < 5; k++) tick();
    check("halt_sticky", {31'd0, halt}, 32'd1);
    // Reset while a load-use stall is active must still clear everything
    load(32'h014C5820, 32'h408);
    EX_MemRead = 1'b1; EX_Rt = 5'd10;
    RESET = 1'b0;
    tick();
    RESET = 1'b1; EX_MemRead = 1'b0;
    settle();
    check("halt_cleared", {31'd0, halt}, 32'd0);
    check("rst2_valid", {31'd0, valid_out}, 32'd0);
    check("rst2_rd1", ReadData1, 32'h0);
    check("rst2_pc4", PCPlus4_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-002 The block SHALL have port RESET, input, 1, the reset: synchronous and active-low (0 = reset, sampled on the CLK rising edge).
REQ-003 The block SHALL have port instruction_in, input, 32, the instruction from the fetch stage.
REQ-004 The block SHALL have port PCPlus4_in, input, 32, PC+4 from the fetch stage.
REQ-005 The block SHALL have port flush, input, 1, a taken jump/branch from the memory stage.
REQ-006 The block SHALL have ports RegWrite_WB (input, 1), WriteReg_WB (input, 5) and WriteData_WB (input, 32), the writeback port.
REQ-007 The block SHALL have ports EX_MemRead (input, 1) and EX_Rt (input, 5), describing the load currently in execute.
REQ-008 The block SHALL have port stall, output, 1, which holds the fetch PC when high.
REQ-009 The block SHALL have ports valid_out (output, 1), PCPlus4_out (output, 32), ReadData1 (output, 32), ReadData2 (output, 32), Imm (output, 32), Rs (output, 5), Rt (output, 5), Rd (output, 5) and shamt (output, 5).
REQ-010 The block SHALL have control outputs RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, BranchNE and Jump (1 bit each), plus ALUControl (output, 4).
REQ-011 The block SHALL have port halt, output, 1, a sticky flag set by the terminate instruction.

Function
REQ-012 The IF/ID latch (instr, pc4, valid) SHALL update on each rising edge of CLK, with priority reset > flush > stall > load.
REQ-013 The latch load SHALL be: instr <= instruction_in; pc4 <= PCPlus4_in; valid <= 1.
REQ-014 On flush=1 the latch SHALL become instr=0x00000000 and valid=0; flush SHALL win when asserted together with stall.
REQ-015 While stall=1 (and flush=0) the latch SHALL hold its contents.
REQ-016 Decode SHALL be combinational from the latch, with zero-cycle latency to the outputs.
REQ-017 The register file SHALL hold 32x32 bits and be written on the rising edge of CLK when RegWrite_WB=1 and WriteReg_WB!=0; register $0 SHALL always read 0.
REQ-018 In a same-cycle write/read to an address other than 0, ReadData1 and ReadData2 SHALL return WriteData_WB (write-through bypass).
REQ-019 stall SHALL equal valid & EX_MemRead & (EX_Rt!=0) & (EX_Rt==Rs | (EX_Rt==Rt & instruction reads Rt)); instructions that read Rt are R-type, sw, beq and bne.
REQ-020 When stall=1 or valid=0, all control outputs SHALL be 0 (bubble) while the data outputs still reflect the latch.
REQ-021 The supported decode SHALL be: R-type funct add, addu, sub, subu, and, or, xor, nor, slt, sll, srl, sra, sllv, srlv, srav, jr; plus lw, sw, beq, bne, addi, addiu, andi, ori, xori, j, jal.
REQ-022 ALUControl SHALL be encoded as: add=0, sub=1, and=2, or=3, xor=4, nor=5, slt=6, sll=7, srl=8, sra=9; the v-variants use the same codes with shamt sourced from the register.
REQ-023 Imm SHALL be sign-extended instr[15:0], except andi, ori and xori, which use zero-extension.
REQ-024 RegDst SHALL be 1 for R-type; ALUSrc SHALL be 1 for lw, sw and the I-type ALU ops; lw SHALL set MemRead, MemtoReg and RegWrite.
REQ-025 jal SHALL set RegWrite and Jump and force Rd=31; jr SHALL set Jump with the target taken from ReadData1.
REQ-026 An unknown opcode or funct SHALL decode as a bubble, with all controls 0.
REQ-027 Instruction 0xFFFFFFFF with valid=1 SHALL set halt on the next edge; halt SHALL remain set until reset, and the instruction SHALL decode as a bubble.
REQ-028 The NOP word 0x00000000 (sll $0,$0,0) SHALL decode with RegWrite=1 to $0, which the register file ignores.

Reset
REQ-029 With RESET=0 at a rising edge, the block SHALL clear the latch (instr=0, pc4=0, valid=0), all 32 registers, and halt.
REQ-030 During reset and in the first cycle after it, the outputs SHALL be: stall=0, valid_out=0, all controls 0, ReadData1/2=0, Imm=0, PCPlus4_out=0.
REQ-031 A reset asserted during a stall or flush SHALL override it.

Verification
REQ-032 The bench SHALL cover: reset, then instruction_in=0x20080005 (addi $8,$0,5), PCPlus4_in=4 -> next cycle valid_out=1, RegWrite=1, ALUSrc=1, Rt=8, Imm=5, ALUControl=0.
REQ-033 The bench SHALL cover: WB write $9=0xDEADBEEF with the latched instr reading rs=$9 in the same cycle -> ReadData1=0xDEADBEEF.
REQ-034 The bench SHALL cover: EX_MemRead=1, EX_Rt=10, latched add $11,$10,$12 -> stall=1, controls 0, latch held; then EX_MemRead=0 -> stall=0 and the add decodes.
REQ-035 The bench SHALL cover: flush=1 and stall=1 together -> next cycle valid_out=0 and instr=0.
REQ-036 The bench SHALL cover: WB write to $0 with 0x1234 -> reading $0 returns 0.
REQ-037 The bench SHALL cover: 0xFFFFFFFF latched -> halt=1 the next cycle, still 1 after 5 more cycles, and 0 after RESET=0.
